// File: rtl/sd_dat_resp_mon.sv
// DAT[0] response monitor for SD write/busy phases: decodes the CRC status token,
// tracks card busy with a programmable timeout and reports sticky result flags.
module sd_dat_resp_mon #(
  parameter int START_WIN = 8,
  parameter int BSY_MIN   = 2,
  parameter int TMO_W     = 24
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             SD_I_CRC_BSY_TRG,
  input  logic             SD_I_BSY_TRG,
  input  logic             SD_I_DAT0,
  input  logic [TMO_W-1:0] SD_I_TMO_LIM,
  output logic             SD_O_ACTIVE,
  output logic             SD_O_CRC_OK,
  output logic             SD_O_CRC_ERR,
  output logic             SD_O_FLASH_ERR,
  output logic             SD_O_NO_RESP,
  output logic             SD_O_BSY_END,
  output logic             SD_O_BSY_TMO,
  output logic [TMO_W-1:0] SD_O_BSY_CNT,
  input  logic             SD_O_ACK,
  output logic [2:0]       dbg_state
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    WAIT_START = 3'd1,
    TOK        = 3'd2,
    TOK_END    = 3'd3,
    BLANK      = 3'd4,
    BUSY       = 3'd5
  } state_t;

  localparam int              BW         = (BSY_MIN > 1) ? $clog2(BSY_MIN) : 1;
  localparam logic [7:0]      WIN_LAST   = 8'(START_WIN - 1);
  localparam logic [BW-1:0]   BLANK_LAST = BW'((BSY_MIN > 0) ? BSY_MIN - 1 : 0);
  localparam logic [TMO_W-1:0] CNT_MAX   = '1;
  localparam state_t          BSY_ENTRY  = (BSY_MIN > 0) ? BLANK : BUSY;

  state_t           state;
  logic [7:0]       win_cnt;
  logic [1:0]       bit_idx;
  logic [2:0]       tok;
  logic [BW-1:0]    blank_cnt;
  logic [TMO_W-1:0] bsy_cnt;
  logic [TMO_W-1:0] cnt_inc;

  // Busy length counts the end-bit (or trigger) cycle as its first cycle and
  // includes the cycle that decides release or timeout.
  assign cnt_inc     = (bsy_cnt == CNT_MAX) ? bsy_cnt : bsy_cnt + TMO_W'(1);
  assign SD_O_ACTIVE = (state != IDLE);
  assign dbg_state   = state;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state          <= IDLE;
      win_cnt        <= '0;
      bit_idx        <= '0;
      tok            <= '0;
      blank_cnt      <= '0;
      bsy_cnt        <= '0;
      SD_O_BSY_CNT   <= '0;
      SD_O_CRC_OK    <= 1'b0;
      SD_O_CRC_ERR   <= 1'b0;
      SD_O_FLASH_ERR <= 1'b0;
      SD_O_NO_RESP   <= 1'b0;
      SD_O_BSY_END   <= 1'b0;
      SD_O_BSY_TMO   <= 1'b0;
    end else begin
      // Clear first so that a flag set later in this block on the same edge wins.
      if (SD_O_ACK) begin
        SD_O_CRC_OK    <= 1'b0;
        SD_O_CRC_ERR   <= 1'b0;
        SD_O_FLASH_ERR <= 1'b0;
        SD_O_NO_RESP   <= 1'b0;
        SD_O_BSY_END   <= 1'b0;
        SD_O_BSY_TMO   <= 1'b0;
      end
      if (SD_I_CRC_BSY_TRG) begin
        state   <= WAIT_START;
        win_cnt <= '0;
      end else if (SD_I_BSY_TRG) begin
        state     <= BSY_ENTRY;
        blank_cnt <= '0;
        bsy_cnt   <= TMO_W'(1);
      end else begin
        case (state)
          IDLE: ;
          WAIT_START: begin
            if (!SD_I_DAT0) begin
              state   <= TOK;
              bit_idx <= 2'd2;
            end else if (win_cnt == WIN_LAST) begin
              SD_O_NO_RESP <= 1'b1;
              state        <= IDLE;
            end else begin
              win_cnt <= win_cnt + 8'd1;
            end
          end
          TOK: begin
            tok[bit_idx] <= SD_I_DAT0;
            if (bit_idx == 2'd0) state <= TOK_END;
            else bit_idx <= bit_idx - 2'd1;
          end
          TOK_END: begin
            if (SD_I_DAT0 && tok == 3'b010)      SD_O_CRC_OK    <= 1'b1;
            else if (SD_I_DAT0 && tok == 3'b101) SD_O_CRC_ERR   <= 1'b1;
            else                                 SD_O_FLASH_ERR <= 1'b1;
            state     <= BSY_ENTRY;
            blank_cnt <= '0;
            bsy_cnt   <= TMO_W'(1);
          end
          BLANK: begin
            bsy_cnt <= cnt_inc;
            if (blank_cnt == BLANK_LAST) state <= BUSY;
            else blank_cnt <= blank_cnt + BW'(1);
          end
          BUSY: begin
            bsy_cnt <= cnt_inc;
            if (SD_I_DAT0) begin
              SD_O_BSY_END <= 1'b1;
              SD_O_BSY_CNT <= cnt_inc;
              state        <= IDLE;
            end else if (SD_I_TMO_LIM != '0 && cnt_inc >= SD_I_TMO_LIM) begin
              SD_O_BSY_TMO <= 1'b1;
              SD_O_BSY_CNT <= cnt_inc;
              state        <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sd_dat_resp_mon.sv
// Bench for sd_dat_resp_mon: directed spec scenarios plus randomized token/busy
// sequences, checked edge by edge against a behavioural model of the DAT0 protocol.
module tb_sd_dat_resp_mon;

  localparam int START_WIN = 8;
  localparam int BSY_MIN   = 2;
  localparam int TMO_W     = 24;

  // Flag vector order: {crc_ok, crc_err, flash_err, no_resp, bsy_end, bsy_tmo}
  localparam logic [5:0] M_OK    = 6'b100000;
  localparam logic [5:0] M_ERR   = 6'b010000;
  localparam logic [5:0] M_FLASH = 6'b001000;
  localparam logic [5:0] M_NORSP = 6'b000100;
  localparam logic [5:0] M_END   = 6'b000010;
  localparam logic [5:0] M_TMO   = 6'b000001;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             crc_trg = 1'b0;
  logic             bsy_trg = 1'b0;
  logic             dat0 = 1'b1;
  logic             ack = 1'b0;
  logic [TMO_W-1:0] tmo_lim = '0;
  logic             active, crc_ok, crc_err, flash_err, no_resp, bsy_end, bsy_tmo;
  logic [TMO_W-1:0] bsy_cnt;
  logic [2:0]       dbg_state;
  logic [5:0]       obs_flags;

  int n_checks = 0;
  int n_fail   = 0;

  bit               seq_q[$];
  logic [30:0]      exp_q[$];
  logic [5:0]       exp_flags = '0;
  logic [TMO_W-1:0] exp_cnt   = '0;

  always #5 clk = ~clk;

  sd_dat_resp_mon #(.START_WIN(START_WIN), .BSY_MIN(BSY_MIN), .TMO_W(TMO_W)) dut (
    .CLK(clk), .RST(rst),
    .SD_I_CRC_BSY_TRG(crc_trg), .SD_I_BSY_TRG(bsy_trg), .SD_I_DAT0(dat0),
    .SD_I_TMO_LIM(tmo_lim),
    .SD_O_ACTIVE(active), .SD_O_CRC_OK(crc_ok), .SD_O_CRC_ERR(crc_err),
    .SD_O_FLASH_ERR(flash_err), .SD_O_NO_RESP(no_resp), .SD_O_BSY_END(bsy_end),
    .SD_O_BSY_TMO(bsy_tmo), .SD_O_BSY_CNT(bsy_cnt), .SD_O_ACK(ack),
    .dbg_state(dbg_state)
  );

  assign obs_flags = {crc_ok, crc_err, flash_err, no_resp, bsy_end, bsy_tmo};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // DAT0 value sampled on edge e after the trigger edge (edge 0); line idles high.
  function automatic bit smp(input int e);
    if (e >= 1 && e - 1 < seq_q.size()) return seq_q[e-1];
    return 1'b1;
  endfunction

  // Outcome of one transaction: which flag rises on which edge, and busy length.
  function automatic void predict(input bit crc, input int lim,
                                  output logic [5:0] cls_m, output int cls_e,
                                  output logic [5:0] bsy_m, output int bsy_e,
                                  output int cnt);
    int s, k, len;
    bit done;
    logic [2:0] t3;
    cls_m = '0; cls_e = -1; bsy_m = '0; bsy_e = -1; cnt = 0; s = 0; done = 1'b0;
    if (crc) begin
      k = -1;
      for (int i = 0; i < START_WIN; i++) if (k < 0 && smp(i + 1) == 1'b0) k = i;
      if (k < 0) begin
        cls_m = M_NORSP; cls_e = START_WIN; done = 1'b1;
      end else begin
        t3 = {smp(k + 2), smp(k + 3), smp(k + 4)};
        cls_e = k + 5;
        if (smp(k + 5) && t3 == 3'b010)      cls_m = M_OK;
        else if (smp(k + 5) && t3 == 3'b101) cls_m = M_ERR;
        else                                 cls_m = M_FLASH;
        s = k + 5;
      end
    end
    for (int e = s + BSY_MIN + 1; e < s + 5000 && !done; e++) begin
      len = e - s + 1;
      if (smp(e)) begin
        bsy_m = M_END; bsy_e = e; cnt = len; done = 1'b1;
      end else if (lim != 0 && len >= lim) begin
        bsy_m = M_TMO; bsy_e = e; cnt = len; done = 1'b1;
      end
    end
  endfunction

  // Runs one trigger + DAT0 sequence; stop_edge >= 0 abandons it after that edge.
  task automatic run_scn(input string tag, input bit crc, input bit both, input int lim,
                         input int ack_a, input int ack_b, input int stop_edge);
    logic [5:0] cls_m, bsy_m, f;
    logic [TMO_W-1:0] c;
    logic [30:0] w;
    int cls_e, bsy_e, cnt_new, fin, last;
    predict(crc || both, lim, cls_m, cls_e, bsy_m, bsy_e, cnt_new);
    fin  = (bsy_e >= 0) ? bsy_e : cls_e;
    last = (stop_edge >= 0) ? stop_edge : fin + 2;
    f = exp_flags;
    c = exp_cnt;
    for (int t = 0; t <= last; t++) begin
      if (t == ack_a || t == ack_b) f = '0;
      if (t == cls_e) f = f | cls_m;
      if (t == bsy_e) begin
        f = f | bsy_m;
        c = TMO_W'(cnt_new);
      end
      exp_q.push_back({(t < fin), f, c});
    end
    for (int t = 0; t <= last; t++) begin
      @(negedge clk);
      crc_trg = (t == 0) && (crc || both);
      bsy_trg = (t == 0) && (!crc || both);
      dat0    = (t == 0) ? 1'b1 : smp(t);
      ack     = (t == ack_a) || (t == ack_b);
      tmo_lim = TMO_W'(lim);
      @(posedge clk);
      #1;
      w = exp_q.pop_front();
      chk($sformatf("%s_act_t%0d", tag, t), 32'(active), 32'(w[30]));
      chk($sformatf("%s_flags_t%0d", tag, t), 32'(obs_flags), 32'(w[29:24]));
      chk($sformatf("%s_cnt_t%0d", tag, t), 32'(bsy_cnt), 32'(w[23:0]));
    end
    exp_flags = f;
    exp_cnt   = c;
  endtask

  task automatic push_n(input int n, input bit v);
    repeat (n) seq_q.push_back(v);
  endtask

  task automatic push_tok(input logic [2:0] t3, input bit endb);
    seq_q.push_back(1'b0);
    seq_q.push_back(t3[2]);
    seq_q.push_back(t3[1]);
    seq_q.push_back(t3[0]);
    seq_q.push_back(endb);
  endtask

  initial begin
    int r, k, z, lim, aa, ab;
    bit crc, both;
    logic [2:0] t3;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    chk("reset_flags", 32'(obs_flags), 32'd0);
    chk("reset_cnt", 32'(bsy_cnt), 32'd0);
    chk("reset_act", 32'(active), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // OK token at offset 2, ten busy-low samples
    seq_q.delete(); push_n(2, 1'b1); push_tok(3'b010, 1'b1); push_n(10, 1'b0); push_n(1, 1'b1);
    run_scn("t1", 1'b1, 1'b0, 0, 0, -1, -1);
    chk("t1_len12", 32'(bsy_cnt), 32'd12);

    // CRC error token, then ACK during blank while still active
    seq_q.delete(); push_tok(3'b101, 1'b1); push_n(5, 1'b0); push_n(1, 1'b1);
    run_scn("t2", 1'b1, 1'b0, 0, 0, 6, -1);

    // No start bit within the window, then start on the last sample
    seq_q.delete();
    run_scn("t3a", 1'b1, 1'b0, 0, 0, -1, -1);
    seq_q.delete(); push_n(7, 1'b1); push_tok(3'b010, 1'b1); push_n(3, 1'b0); push_n(1, 1'b1);
    run_scn("t3b", 1'b1, 1'b0, 0, 0, -1, -1);

    // Missing token: busy low reads as token 000 with end bit 0
    seq_q.delete(); push_n(50, 1'b0); push_n(1, 1'b1);
    run_scn("t4", 1'b1, 1'b0, 0, 0, -1, -1);

    // R1b busy with timeout 20, then timeout disabled over 1000 low cycles
    seq_q.delete(); push_n(60, 1'b0);
    run_scn("t5a", 1'b0, 1'b0, 20, 0, -1, -1);
    chk("t5a_len20", 32'(bsy_cnt), 32'd20);
    seq_q.delete(); push_n(1000, 1'b0); push_n(1, 1'b1);
    run_scn("t5b", 1'b0, 1'b0, 0, 0, -1, -1);

    // ACK on the same edge the OK flag is set
    seq_q.delete(); push_tok(3'b010, 1'b1); push_n(5, 1'b0); push_n(1, 1'b1);
    run_scn("t6a", 1'b1, 1'b0, 0, 0, 5, -1);

    // Re-trigger while in busy: restart without BSY_END, flags preserved
    seq_q.delete(); push_tok(3'b010, 1'b1); push_n(40, 1'b0);
    run_scn("t6b", 1'b1, 1'b0, 0, 0, -1, 12);
    seq_q.delete(); push_n(1, 1'b1); push_tok(3'b101, 1'b1); push_n(4, 1'b0); push_n(1, 1'b1);
    run_scn("t6c", 1'b1, 1'b0, 0, -1, -1, -1);

    // Both triggers together: token path wins
    seq_q.delete(); push_tok(3'b010, 1'b1); push_n(3, 1'b0); push_n(1, 1'b1);
    run_scn("both", 1'b0, 1'b1, 0, 0, -1, -1);

    // Reset asserted while shifting in the token
    seq_q.delete(); push_tok(3'b010, 1'b1); push_n(5, 1'b0); push_n(1, 1'b1);
    run_scn("rstpre", 1'b1, 1'b0, 0, -1, -1, 2);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_flags", 32'(obs_flags), 32'd0);
    chk("rst_mid_cnt", 32'(bsy_cnt), 32'd0);
    chk("rst_mid_act", 32'(active), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    exp_flags = '0;
    exp_cnt   = '0;

    // Randomized transactions
    for (r = 0; r < 60; r++) begin
      seq_q.delete();
      crc  = 1'($urandom_range(0, 1));
      both = ($urandom_range(0, 7) == 0);
      if (crc || both) begin
        k = $urandom_range(0, START_WIN);
        push_n(k, 1'b1);
        if (k < START_WIN) begin
          case ($urandom_range(0, 2))
            0: t3 = 3'b010;
            1: t3 = 3'b101;
            default: t3 = 3'($urandom_range(0, 7));
          endcase
          push_tok(t3, ($urandom_range(0, 3) != 0));
        end
      end
      z = $urandom_range(0, 40);
      push_n(z, 1'b0);
      if ($urandom_range(0, 3) == 0) begin
        push_n(1, 1'b1);
        push_n($urandom_range(0, 10), 1'b0);
      end
      push_n(1, 1'b1);
      lim = ($urandom_range(0, 1) == 1) ? 0 : $urandom_range(3, 40);
      aa  = ($urandom_range(0, 1) == 1) ? 0 : -1;
      ab  = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 30) : -1;
      run_scn($sformatf("rnd%0d", r), crc, both, lim, aa, ab,
              ($urandom_range(0, 9) == 0) ? $urandom_range(1, 6) : -1);
    end

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
